memory_port_arbiter: RTL

Shares one 32-bit-word unified main memory between the instruction cache and the data cache of the pipelined CPU. Grants one cache at a time and serializes each 128-bit instruction-block refill into four word transfers. Passes 32-bit data-block reads and writes through as single transfers. Sits between both caches' memory-side ports and the single memory model, replacing the separate instruction and data memories.

---
 rtl/memory_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//
// Shares one word-wide main memory between the instruction cache and the data
// cache. One side is granted at a time. An instruction-block refill becomes
// four single-word reads, separated by one strobe-free gap cycle. A data-block
// read or write passes through as a single transfer.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on a simultaneous request, the side not granted last wins.
//   undefined : fixed priority, data wins contention.
//
// Ports
//   CLK, RESET                  clock (rising edge), asynchronous active-high reset
//   ins_read / ins_address      instruction block read request and block index
//   ins_readdata / ins_busywait assembled 128-bit block, instruction stall
//   data_read / data_write      data block read / write-back request
//   data_address / data_writedata / data_readdata / data_busywait
//   mem_read / mem_write        memory strobes (registered)
//   mem_address / mem_writedata memory word address and write data (registered)
//   mem_readdata / mem_busywait memory read data and busy
module memory_port_arbiter #(
  parameter int unsigned        MEM_AW    = 9,
  parameter logic [MEM_AW-1:0]  DATA_BASE = MEM_AW'(256)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ins_read,
  input  logic [5:0]        ins_address,
  output logic [127:0]      ins_readdata,
  output logic              ins_busywait,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [5:0]        data_address,
  input  logic [31:0]       data_writedata,
  output logic [31:0]       data_readdata,
  output logic              data_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [2:0] {StIdle, StDAcc, StIAcc, StIGap, StResp} state_e;

  state_e              state_q;
  logic [1:0]          beat_q;
  logic                grant_data_q;  // side owning the current transaction
  logic                mem_read_q;
  logic                mem_write_q;
  logic [MEM_AW-1:0]   mem_address_q;
  logic [31:0]         mem_writedata_q;
  logic [127:0]        ins_readdata_q;
  logic [31:0]         data_readdata_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_grant_data_q;
`endif

  logic                data_req;
  logic                grant_data;
  logic                xfer_done;
  logic [MEM_AW-1:0]   data_mem_addr;
  logic [MEM_AW-1:0]   ins_mem_addr;
  logic [MEM_AW-1:0]   ins_first_addr;

  assign data_req       = data_read | data_write;
  assign data_mem_addr  = DATA_BASE + MEM_AW'(data_address);
  assign ins_mem_addr   = MEM_AW'({ins_address, beat_q});
  assign ins_first_addr = MEM_AW'({ins_address, 2'b00});
  // A transfer completes on the edge where our strobe is up and memory is not busy.
  assign xfer_done      = (mem_read_q | mem_write_q) & ~mem_busywait;

`ifdef ARB_ROUND_ROBIN_EN
  // Under contention the data side wins only if instruction was granted last.
  assign grant_data = data_req & (~ins_read | ~last_grant_data_q);
`else
  assign grant_data = data_req;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q           <= StIdle;
      beat_q            <= 2'd0;
      grant_data_q      <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_writedata_q   <= '0;
      ins_readdata_q    <= '0;
      data_readdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_data_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_data) begin
            state_q         <= StDAcc;
            grant_data_q    <= 1'b1;
            mem_address_q   <= data_mem_addr;
            mem_writedata_q <= data_writedata;
            // A simultaneous read is left pending and serviced afterwards.
            mem_write_q     <= data_write;
            mem_read_q      <= ~data_write;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_data_q <= 1'b1;
`endif
          end else if (ins_read) begin
            state_q       <= StIAcc;
            grant_data_q  <= 1'b0;
            beat_q        <= 2'd0;
            mem_read_q    <= 1'b1;
            mem_address_q <= ins_first_addr;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_data_q <= 1'b0;
`endif
          end
        end

        StDAcc: begin
          if (xfer_done) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) begin
              data_readdata_q <= mem_readdata;
            end
            state_q <= StResp;
          end else begin
            // Requester inputs are resampled every cycle of the access.
            mem_address_q   <= data_mem_addr;
            mem_writedata_q <= data_writedata;
            mem_write_q     <= data_write;
            mem_read_q      <= ~data_write;
          end
        end

        StIAcc: begin
          if (xfer_done) begin
            mem_read_q <= 1'b0;
            ins_readdata_q[{beat_q, 5'd0} +: 32] <= mem_readdata;
            if (beat_q == 2'd3) begin
              state_q <= StResp;
            end else begin
              beat_q  <= beat_q + 2'd1;
              state_q <= StIGap;
            end
          end else begin
            mem_address_q <= ins_mem_addr;
          end
        end

        StIGap: begin
          // beat_q already points at the next word.
          mem_read_q    <= 1'b1;
          mem_address_q <= ins_mem_addr;
          state_q       <= StIAcc;
        end

        StResp: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign ins_readdata  = ins_readdata_q;
  assign data_readdata = data_readdata_q;

  assign ins_busywait  = ~RESET & ins_read & ~((state_q == StResp) & ~grant_data_q);
  assign data_busywait = ~RESET & data_req & ~((state_q == StResp) & grant_data_q);

endmodule
